// File: rtl/output_collector_nxn.sv
// output_collector_nxn
// Collects N diagonal wavefronts (2N-1 lanes each) from a systolic array and
// assembles them into an N x N matrix. A complete matrix is presented on
// data_out with a valid/ready handshake. One finished matrix can be parked
// internally while the output is stalled; until it drains, the input is
// closed and any wavefront is flagged as an error.
// Optional feature: define OUTPUT_COLLECTOR_ERR_CNT_EN to add the err_count
// port, a saturating 8-bit count of err pulses.
module output_collector_nxn #(
  parameter int N            = 3,
  parameter int OUTPUT_WIDTH = 16,
  parameter int TRANSPOSE    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OUTPUT_WIDTH-1:0] data_in [0:2*N-2],
  input  logic [0:2*N-2]          valid_in,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] data_out [0:N-1][0:N-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err
`ifdef OUTPUT_COLLECTOR_ERR_CNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int L  = 2*N-1;
  localparam int IW = $clog2(N);

  typedef enum logic [0:0] {COLLECT = 1'b0, HOLD = 1'b1} state_t;
  typedef logic [OUTPUT_WIDTH-1:0] mat_t [0:N-1][0:N-1];

  state_t          state_r, state_nxt;
  logic [IW-1:0]   wave_idx_r, wave_idx_nxt;
  mat_t            collect_r, collect_nxt;
  mat_t            out_buf_r, out_buf_nxt;
  logic            out_valid_r, out_valid_nxt;
  logic            err_r, err_nxt;

  logic            idle_s;
  logic            mask_ok_s;
  logic            wave0_s;
  logic [IW-1:0]   wave_sel_s;
  mat_t            merged_s;

  // Lane mask wave k must carry: lanes k..2N-2-k set, all others clear.
  function automatic logic [0:L-1] wave_mask(input logic [IW-1:0] k);
    logic [0:L-1] m;
    m = {L{1'b0}};
    for (int i = 0; i < L; i++) begin
      m[i] = (i >= int'(k)) && (i <= L-1-int'(k));
    end
    return m;
  endfunction

  assign idle_s    = (valid_in == {L{1'b0}});
  assign mask_ok_s = (valid_in == wave_mask(wave_idx_r));
  assign wave0_s   = (valid_in == wave_mask({IW{1'b0}}));

  // Wave being written: the expected one, or wave 0 when an error restarts collection.
  always_comb begin
    if (mask_ok_s) begin
      wave_sel_s = wave_idx_r;
    end else begin
      wave_sel_s = {IW{1'b0}};
    end
  end

  // Overlay the selected wave onto the collect buffer. Logical element [a][b]
  // belongs to wave min(a,b) and arrives on lane N-1+a-b; with TRANSPOSE the
  // stored position [r][c] holds logical element [c][r].
  always_comb begin
    merged_s = collect_r;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (int'(wave_sel_s) == ((r < c) ? r : c)) begin
          merged_s[r][c] = data_in[(TRANSPOSE != 0) ? (N-1+c-r) : (N-1+r-c)];
        end else begin
          merged_s[r][c] = collect_r[r][c];
        end
      end
    end
  end

  // Next-state and buffer update logic of the collect/hold controller.
  always_comb begin
    state_nxt     = state_r;
    wave_idx_nxt  = wave_idx_r;
    collect_nxt   = collect_r;
    out_buf_nxt   = out_buf_r;
    out_valid_nxt = out_valid_r & ~out_ready;
    err_nxt       = 1'b0;
    case (state_r)
      COLLECT: begin
        if (idle_s) begin
          state_nxt = COLLECT;
        end else if (mask_ok_s) begin
          if (wave_idx_r == IW'(N-1)) begin
            wave_idx_nxt = {IW{1'b0}};
            if (!out_valid_r || out_ready) begin
              out_buf_nxt   = merged_s;
              out_valid_nxt = 1'b1;
            end else begin
              collect_nxt = merged_s;
              state_nxt   = HOLD;
            end
          end else begin
            collect_nxt  = merged_s;
            wave_idx_nxt = wave_idx_r + IW'(1);
          end
        end else begin
          err_nxt = 1'b1;
          if (wave0_s) begin
            collect_nxt  = merged_s;
            wave_idx_nxt = IW'(1);
          end else begin
            wave_idx_nxt = {IW{1'b0}};
          end
        end
      end
      HOLD: begin
        err_nxt = ~idle_s;
        if (out_valid_r && out_ready) begin
          out_buf_nxt   = collect_r;
          out_valid_nxt = 1'b1;
          state_nxt     = COLLECT;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: begin
        state_nxt    = COLLECT;
        wave_idx_nxt = {IW{1'b0}};
      end
    endcase
  end

  // State, buffers and outputs registered with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= COLLECT;
      wave_idx_r  <= {IW{1'b0}};
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          collect_r[r][c] <= {OUTPUT_WIDTH{1'b0}};
          out_buf_r[r][c] <= {OUTPUT_WIDTH{1'b0}};
        end
      end
    end else begin
      state_r     <= state_nxt;
      wave_idx_r  <= wave_idx_nxt;
      out_valid_r <= out_valid_nxt;
      err_r       <= err_nxt;
      collect_r   <= collect_nxt;
      out_buf_r   <= out_buf_nxt;
    end
  end

  assign in_ready  = (state_r == COLLECT);
  assign data_out  = out_buf_r;
  assign out_valid = out_valid_r;
  assign err       = err_r;

`ifdef OUTPUT_COLLECTOR_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
    end else if (err_nxt && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_count = err_cnt_r;
`endif

endmodule

// File: tb/tb_output_collector_nxn.sv
// Scoreboard bench for output_collector_nxn: two instances (TRANSPOSE 0 and 1)
// share all inputs; a reference model assembles matrices from the lane rules
// and queues them; a negedge monitor compares every presented matrix.
module tb_output_collector_nxn;
  localparam int N = 3;
  localparam int W = 16;
  localparam int L = 2*N-1;

  typedef logic [W-1:0] mat_t [0:N-1][0:N-1];
  typedef logic [W-1:0] lanes_t [0:L-1];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_in [0:L-1];
  logic [0:L-1] valid_in = '0;
  logic         out_ready = 1'b1;

  logic         in_ready0, out_valid0, err0;
  logic         in_ready1, out_valid1, err1;
  mat_t         data_out0, data_out1;
`ifdef OUTPUT_COLLECTOR_ERR_CNT_EN
  logic [7:0]   err_count0, err_count1;
`endif

  int checks = 0;
  int errors = 0;

  mat_t q0[$];
  mat_t q1[$];
  mat_t pm;
  int   exp_k = 0;

  always #5 clk = ~clk;

  output_collector_nxn #(.N(N), .OUTPUT_WIDTH(W), .TRANSPOSE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .in_ready(in_ready0), .data_out(data_out0), .out_valid(out_valid0),
    .out_ready(out_ready), .err(err0)
`ifdef OUTPUT_COLLECTOR_ERR_CNT_EN
    , .err_count(err_count0)
`endif
  );

  output_collector_nxn #(.N(N), .OUTPUT_WIDTH(W), .TRANSPOSE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .in_ready(in_ready1), .data_out(data_out1), .out_valid(out_valid1),
    .out_ready(out_ready), .err(err1)
`ifdef OUTPUT_COLLECTOR_ERR_CNT_EN
    , .err_count(err_count1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_mat(input string name, input mat_t act, input mat_t exp);
    int bad;
    bad = 0;
    checks++;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (bad == 0 && act[r][c] !== exp[r][c]) begin
          bad = 1;
          $display("FAIL %s: element [%0d][%0d] got %0d expected %0d", name, r, c, act[r][c], exp[r][c]);
        end
    if (bad != 0) errors++;
  endtask

  function automatic logic [0:L-1] wmask(input int k);
    logic [0:L-1] m;
    for (int i = 0; i < L; i++) m[i] = (i >= k) && (i <= L-1-k);
    return m;
  endfunction

  // Place wave k's lanes into the partial matrix using the forward lane rules.
  task automatic place(input int k, input logic [0:L-1] m, input lanes_t d);
    for (int i = 0; i < L; i++)
      if (m[i]) begin
        if (i <= N-1) pm[k][N-1-i+k] = d[i];
        else          pm[i-N+1+k][k] = d[i];
      end
  endtask

  task automatic push_matrix();
    mat_t mt;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mt[c][r] = pm[r][c];
    q0.push_back(pm);
    q1.push_back(mt);
  endtask

  // Queue depth tells the model where the DUT stands: 2 pending matrices = hold.
  task automatic model_wave(input logic [0:L-1] m, input lanes_t d, output logic exp_err);
    if (q0.size() == 2) begin
      exp_err = 1'b1;
    end else if (m == wmask(exp_k)) begin
      exp_err = 1'b0;
      place(exp_k, m, d);
      if (exp_k == N-1) begin
        push_matrix();
        exp_k = 0;
      end else begin
        exp_k++;
      end
    end else begin
      exp_err = 1'b1;
      if (m == wmask(0)) begin
        place(0, m, d);
        exp_k = 1;
      end else begin
        exp_k = 0;
      end
    end
  endtask

  task automatic send(input logic [0:L-1] m, input lanes_t d, input logic rdy);
    logic e;
    out_ready = rdy;
    chk("in_ready0", in_ready0, q0.size() < 2);
    chk("in_ready1", in_ready1, q1.size() < 2);
    model_wave(m, d, e);
    valid_in = m;
    data_in  = d;
    @(posedge clk); #1;
    valid_in = '0;
    chk("err0", err0, e);
    chk("err1", err1, e);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int j = 0; j < n; j++) begin
      out_ready = rdy;
      valid_in  = '0;
      @(posedge clk); #1;
      chk("err_idle", err0 | err1, 1'b0);
    end
  endtask

  task automatic rnd_lanes(output lanes_t d);
    for (int i = 0; i < L; i++) d[i] = 16'($urandom);
  endtask

  task automatic send_matrix(input logic rdy, input int gap);
    lanes_t d;
    for (int k = 0; k < N; k++) begin
      rnd_lanes(d);
      send(wmask(k), d, rdy);
      idle(gap, rdy);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_in = '0;
    q0.delete();
    q1.delete();
    exp_k = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready0 & in_ready1, 1'b1);
    chk("rst_out_valid", out_valid0 | out_valid1, 1'b0);
    chk("rst_err", err0 | err1, 1'b0);
  endtask

  // Monitor: compare presented matrix with the oldest expected; pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_valid0: got 1 expected 0 (no matrix pending)");
        end else begin
          chk_mat("data_out0", data_out0, q0[0]);
          if (out_ready) void'(q0.pop_front());
        end
      end
      if (out_valid1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_valid1: got 1 expected 0 (no matrix pending)");
        end else begin
          chk_mat("data_out1", data_out1, q1[0]);
          if (out_ready) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    lanes_t d;
    mat_t   e33, e34;
    for (int i = 0; i < L; i++) data_in[i] = '0;
    e33 = '{'{16'd3, 16'd2, 16'd1}, '{16'd4, 16'd13, 16'd12}, '{16'd5, 16'd14, 16'd23}};
    e34 = '{'{16'd3, 16'd4, 16'd5}, '{16'd2, 16'd13, 16'd14}, '{16'd1, 16'd12, 16'd23}};

    do_reset();

    // Directed example matrix, both orientations.
    d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    send(wmask(0), d, 1'b1);
    d = '{16'd0, 16'd12, 16'd13, 16'd14, 16'd0};
    send(wmask(1), d, 1'b1);
    d = '{16'd0, 16'd0, 16'd23, 16'd0, 16'd0};
    send(wmask(2), d, 1'b1);
    @(negedge clk);
    chk("ex_out_valid", out_valid0 & out_valid1, 1'b1);
    chk_mat("ex_matrix", data_out0, e33);
    chk_mat("ex_matrix_t", data_out1, e34);
    @(posedge clk); #1;

    // Stalled output: second matrix parks, a wave during hold is dropped.
    send_matrix(1'b0, 0);
    send_matrix(1'b0, 0);
    idle(2, 1'b0);
    rnd_lanes(d);
    send(wmask(0), d, 1'b0);
    idle(4, 1'b1);

    // Broken sequence recovery.
    rnd_lanes(d);
    send(wmask(0), d, 1'b1);
    send(5'b00100, d, 1'b1);
    idle(2, 1'b1);
    send_matrix(1'b1, 0);
    idle(2, 1'b1);

    // Idle gaps between waves, then reset mid-collection.
    send_matrix(1'b1, 3);
    rnd_lanes(d);
    send(wmask(0), d, 1'b1);
    send(wmask(1), d, 1'b1);
    do_reset();
    idle(2, 1'b1);
    send_matrix(1'b1, 0);
    idle(2, 1'b1);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      int   sel;
      logic rdy;
      sel = $urandom_range(0, 9);
      rdy = ($urandom_range(0, 3) != 0);
      rnd_lanes(d);
      if (sel < 2)      idle(1, rdy);
      else if (sel < 8) send(wmask(exp_k), d, rdy);
      else              send(5'($urandom_range(1, 31)), d, rdy);
    end

`ifdef OUTPUT_COLLECTOR_ERR_CNT_EN
    do_reset();
    for (int j = 0; j < 300; j++) send(5'b10000, d, 1'b1);
    chk("err_count_sat0", err_count0, 8'd255);
    chk("err_count_sat1", err_count1, 8'd255);
    do_reset();
    chk("err_count_rst", err_count0 | err_count1, 8'd0);
`endif

    // Drain and confirm nothing is left.
    idle(6, 1'b1);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_out_valid", out_valid0 | out_valid1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
